// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core front end.
package riscv_pkg;

  // addi x0, x0, 0: the canonical NOP, used to fill pipeline bubbles
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetchStateT;

endpackage : riscv_pkg

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: fetch PC, variable-latency imem handshake,
// one-entry skid buffer and the F/D pipeline register feeding decode.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        pc_srcE,
  input  logic [31:0] pc_targetE,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic [31:0] pcplus4D,
  output logic        validD,
  output logic        fetch_busy
);

  fetchStateT  state;
  logic [31:0] pcF;
  logic [31:0] pcPlus4F;
  logic [31:0] skidInstr;
  logic [31:0] skidPc;
  logic [31:0] redirectTarget;

  logic        ackF;
  logic        fdLoad;
  logic [31:0] fdLoadInstr;
  logic [31:0] fdLoadPc;

  // A request is live in FETCH and DRAIN; the address is simply pcF, which
  // only moves on an accepted ack, so it stays stable across wait states.
  assign imem_req   = (state == FETCH) || (state == DRAIN);
  assign imem_addr  = pcF;
  assign ackF       = imem_req && imem_ack;
  assign fetch_busy = imem_req && !imem_ack;
  assign pcPlus4F   = pcF + 32'd4;

  // Select what, if anything, the F/D register should accept this cycle
  always_comb begin
    fdLoad      = 1'b0;
    fdLoadInstr = imem_rdata;
    fdLoadPc    = pcF;
    case (state)
      FETCH: begin
        if (ackF && !pc_srcE && !stallD && !flushD) begin
          fdLoad      = 1'b1;
          fdLoadInstr = imem_rdata;
          fdLoadPc    = pcF;
        end
      end
      HOLD: begin
        if (!pc_srcE && !stallD && !flushD) begin
          fdLoad      = 1'b1;
          fdLoadInstr = skidInstr;
          fdLoadPc    = skidPc;
        end
      end
      default: begin
        fdLoad = 1'b0;
      end
    endcase
  end

  // Fetch sequencer: PC, skid buffer and pending redirect target
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      pcF            <= RESET_PC;
      skidInstr      <= NOP_INSTR;
      skidPc         <= 32'd0;
      redirectTarget <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
        end
        FETCH: begin
          if (ackF) begin
            if (pc_srcE) begin
              // word belongs to the wrong path; refetch from the target
              pcF <= pc_targetE;
            end else begin
              pcF <= pcPlus4F;
              if (stallD || flushD) begin
                // decode cannot take the word now; park it
                skidInstr <= imem_rdata;
                skidPc    <= pcF;
                state     <= HOLD;
              end
            end
          end else if (pc_srcE) begin
            // cannot retract the address mid-request; remember where to go
            redirectTarget <= pc_targetE;
            state          <= DRAIN;
          end
        end
        DRAIN: begin
          if (ackF) begin
            pcF   <= pc_srcE ? pc_targetE : redirectTarget;
            state <= FETCH;
          end else if (pc_srcE) begin
            redirectTarget <= pc_targetE;
          end
        end
        HOLD: begin
          if (pc_srcE) begin
            pcF   <= pc_targetE;
            state <= FETCH;
          end else if (!stallD && !flushD) begin
            state <= FETCH;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // F/D pipeline register: reset > flush > stall > load > bubble
  always_ff @(posedge clk) begin
    if (reset || flushD) begin
      instrD   <= NOP_INSTR;
      pcD      <= 32'd0;
      pcplus4D <= 32'd0;
      validD   <= 1'b0;
    end else if (stallD) begin
      instrD   <= instrD;
      pcD      <= pcD;
      pcplus4D <= pcplus4D;
      validD   <= validD;
    end else if (fdLoad) begin
      instrD   <= fdLoadInstr;
      pcD      <= fdLoadPc;
      pcplus4D <= fdLoadPc + 32'd4;
      validD   <= 1'b1;
    end else begin
      instrD   <= NOP_INSTR;
      pcD      <= 32'd0;
      pcplus4D <= 32'd0;
      validD   <= 1'b0;
    end
  end

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a stream-level reference model.
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stallD;
  logic        flushD;
  logic        pc_srcE;
  logic [31:0] pc_targetE;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic [31:0] pcplus4D;
  logic        validD;
  logic        fetch_busy;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .stallD     (stallD),
    .flushD     (flushD),
    .pc_srcE    (pc_srcE),
    .pc_targetE (pc_targetE),
    .instrD     (instrD),
    .pcD        (pcD),
    .pcplus4D   (pcplus4D),
    .validD     (validD),
    .fetch_busy (fetch_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Instruction memory contents as a pure function of the address
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Reference model state: next PC decode should receive, pending redirect
  logic [31:0] expPc;
  logic        pend;
  logic [31:0] pendTgt;
  int          sinceReset;
  int          loads;
  int          waitLeft;
  logic        needNew;

  // Values seen during the cycle before the edge
  logic        pReset, pStall, pFlush, pSrc, pReq, pAck, pValid;
  logic [31:0] pTgt, pAddr, pInstr, pPc, pPc4;

  task automatic checkBubble(input string tag);
    checkEq({tag, "_valid"}, 32'(validD), 32'd0);
    checkEq({tag, "_instr"}, instrD, NOP_INSTR);
    checkEq({tag, "_pc"}, pcD, 32'd0);
    checkEq({tag, "_pc4"}, pcplus4D, 32'd0);
  endtask

  // mode 0: zero-wait memory, no hazards; mode 1: random everything
  task automatic runCycle(input int mode, input logic forceReset);
    // ---- drive inputs for this cycle ----
    if (mode == 0) begin
      reset   = forceReset;
      stallD  = 1'b0;
      flushD  = 1'b0;
      pc_srcE = 1'b0;
      pc_targetE = 32'd0;
      imem_ack = imem_req;
    end else begin
      reset   = forceReset || ($urandom_range(0, 119) == 0);
      stallD  = ($urandom_range(0, 4) == 0);
      flushD  = ($urandom_range(0, 9) == 0);
      pc_srcE = (sinceReset > 0) && ($urandom_range(0, 11) == 0);
      pc_targetE = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0
                                              : ($urandom() & 32'h0000_FFFC);
      if (imem_req) begin
        if (needNew) begin
          waitLeft = $urandom_range(0, 3);
          needNew  = 1'b0;
        end
        imem_ack = (waitLeft == 0);
        if (waitLeft > 0) waitLeft--;
      end else begin
        imem_ack = ($urandom_range(0, 3) == 0);
      end
    end
    imem_rdata = imem_req ? memWord(imem_addr) : $urandom();
    #1;
    checkEq("busy", 32'(fetch_busy), 32'(imem_req && !imem_ack));
    pReset = reset;  pStall = stallD;  pFlush = flushD;
    pSrc   = pc_srcE; pTgt  = pc_targetE;
    pReq   = imem_req; pAck = imem_ack; pAddr = imem_addr;
    pInstr = instrD; pPc = pcD; pPc4 = pcplus4D; pValid = validD;

    // ---- evaluate the edge ----
    @(posedge clk);
    #1;
    if (pReset) begin
      checkBubble("rst");
      checkEq("rst_req", 32'(imem_req), 32'd0);
      checkEq("rst_addr", imem_addr, RESET_PC);
      expPc      = RESET_PC;
      pend       = 1'b0;
      sinceReset = 0;
      needNew    = 1'b1;
    end else begin
      sinceReset++;
      if (sinceReset == 1) begin
        checkEq("first_req", 32'(imem_req), 32'd1);
        checkEq("first_addr", imem_addr, RESET_PC);
      end
      if (pFlush || (!pStall && pSrc)) begin
        checkBubble("flush");
      end else if (pStall) begin
        checkEq("hold_valid", 32'(validD), 32'(pValid));
        checkEq("hold_instr", instrD, pInstr);
        checkEq("hold_pc", pcD, pPc);
        checkEq("hold_pc4", pcplus4D, pPc4);
      end else if (validD) begin
        checkEq("load_pc", pcD, expPc);
        checkEq("load_instr", instrD, memWord(expPc));
        checkEq("load_pc4", pcplus4D, expPc + 32'd4);
        $display("load pc=%h instr=%h", pcD, instrD);
        expPc = expPc + 32'd4;
        loads++;
      end else begin
        checkBubble("idle");
      end
      if (mode == 0 && sinceReset >= 2) checkEq("zero_wait_load", 32'(validD), 32'd1);
      if (pSrc) expPc = pTgt;
      if (pReq && !pAck) begin
        checkEq("wait_req", 32'(imem_req), 32'd1);
        checkEq("wait_addr", imem_addr, pAddr);
      end
      if (pReq && pSrc) begin
        pend    = 1'b1;
        pendTgt = pTgt;
      end
      if (pReq && pAck) begin
        if (pend) begin
          checkEq("redir_req", 32'(imem_req), 32'd1);
          checkEq("redir_addr", imem_addr, pendTgt);
        end
        pend    = 1'b0;
        needNew = 1'b1;
      end else if (!pReq && pSrc) begin
        checkEq("hold_redir_req", 32'(imem_req), 32'd1);
        checkEq("hold_redir_addr", imem_addr, pTgt);
      end
    end
  endtask

  initial begin
    reset = 1'b1; stallD = 1'b0; flushD = 1'b0; pc_srcE = 1'b0;
    pc_targetE = 32'd0; imem_ack = 1'b0; imem_rdata = 32'd0;
    expPc = RESET_PC; pend = 1'b0; pendTgt = 32'd0; sinceReset = 0;
    loads = 0; waitLeft = 0; needNew = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) runCycle(0, 1'b1);
    for (int i = 0; i < 40; i++) runCycle(0, 1'b0);
    for (int i = 0; i < 2; i++) runCycle(1, 1'b1);
    for (int i = 0; i < 2500; i++) runCycle(1, 1'b0);
    for (int i = 0; i < 2; i++) runCycle(0, 1'b1);
    for (int i = 0; i < 20; i++) runCycle(0, 1'b0);
    checkEq("progress", 32'(loads > 200), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_fetch_unit
